fifo_rd_streamer: RTL and testbench
===================================

// Module: fifo_rd_streamer
// PURPOSE
//  Read-side master for the async FIFO. Lives in the clk_rd domain.
//  - Pops words through the FIFO read port (rd_en/rdata/empty).
//  - Absorbs the FIFO's 1-cycle read latency in a 2-entry buffer.
//  - Presents the words as a valid/ready stream at 1 word/clk sustained.
//  - Never issues a read while empty=1, so the FIFO's underflow never fires.
// PARAMETERS
//  WIDTH      8   data width; equals the FIFO WIDTH
//  CNT_WIDTH  16  width of the delivered-word counter
// PORTS
//  clk            in   1          read-domain clock (the FIFO's clk_rd)
//  rst_n          in   1          asynchronous, active-low reset
//  en             in   1          1 = pull words from the FIFO
//  flush          in   1          sync pulse: discard buffered and in-flight data
//  fifo_empty     in   1          FIFO empty flag
//  fifo_rdata     in   WIDTH      FIFO read data, valid 1 clk after fifo_rd_en
//  fifo_underflow in   1          FIFO underflow flag (monitored only)
//  fifo_rd_en     out  1          FIFO read strobe
//  m_valid        out  1          stream word valid
//  m_data         out  WIDTH      stream word
//  m_ready        in   1          downstream accepts the word
//  word_count     out  CNT_WIDTH  words accepted downstream (m_valid&m_ready); wraps
//  busy           out  1          state!=IDLE or buffer not empty
//  err_underflow  out  1          sticky; set on fifo_underflow=1; cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0): every output is 0.
//    State=IDLE, buffer empty, inflight=0, drop=0.
//  FSM:
//    IDLE : en=1 -> ACTIVE.
//    ACTIVE : reads are issued. en=0 -> STOP.
//    STOP : no new reads. Exit to IDLE when inflight=0 and no return is pending.
//      en=1 in STOP -> ACTIVE.
//    Buffered words keep draining downstream in every state.
//  Issue rule (combinational, ACTIVE only):
//    fifo_rd_en = !fifo_empty && !flush && (count + inflight - pop) < 2.
//    count = buffer occupancy (0..2); pop = m_valid & m_ready.
//  inflight: set by fifo_rd_en; return lands the next cycle; max 1 outstanding.
//  Latency: fifo_rd_en in cycle N -> fifo_rdata sampled at end of N+1 -> m_valid in N+2.
//  Sustained throughput: 1 word/clk with m_ready held high and the FIFO non-empty.
//  Stream rules:
//    - m_data is the buffer head; it is held stable while m_valid & !m_ready.
//    - FIFO order is preserved.
//    - Push and pop in the same cycle is legal at count=1 and at count=2.
//  The issue rule guarantees no push ever reaches a full buffer.
//    If one does anyway: drop the word and set err_underflow (design bug, asserted in sim).
//  Flush, cycle F:
//    - Buffer cleared at the end of F; m_valid=0 from F+1.
//    - No read issued in F.
//    - An outstanding return is discarded via a drop flag.
//    - State -> IDLE, or ACTIVE if en=1 in F.
//    - word_count is not cleared.
//  Stale empty: fifo_empty is synchronizer-delayed, so it is pessimistic. No special handling.
//  en deasserted mid-burst: words already issued are still delivered. Nothing is lost.
//  word_count: +1 per handshake; modulo 2^CNT_WIDTH.
// STRUCTURE
//  Package fifo_rd_pkg:
//    - state_t enum {IDLE, ACTIVE, STOP}
//    - localparam BUF_DEPTH=2
//  Sub-module stream_skid_buf:
//    - 2-entry register FIFO
//    - ports push/push_data/pop/count/head_data/clear; async reset
//  Top level holds the FSM, the issue logic, inflight/drop, word_count and the error flag.
// TESTING
//  1 Preload 5 words (0x11..0x15), en=1, m_ready=1.
//    -> rd_en 5 consecutive cycles; m_valid 2 clk after the first rd_en.
//    -> data 0x11..0x15 back-to-back; word_count=5.
//  2 Preload 8 words, m_ready=0.
//    -> exactly 2 reads issued; m_data=first word, held stable.
//    -> Raise m_ready: remaining 6 words follow in order, no gaps after the first.
//  3 FIFO empty, en=1.
//    -> fifo_rd_en never asserts; fifo_underflow stays 0; err_underflow=0; busy=1 (ACTIVE).
//  4 Flush one cycle after a read issue, buffer holding 1 word.
//    -> m_valid=0 next cycle; the in-flight word is never presented.
//    -> Next words resume in FIFO order.
//  5 Drop en mid-stream with 1 read outstanding.
//    -> the outstanding word is delivered; state STOP->IDLE; busy falls after the last pop.
//  6 Assert rst_n=0 asynchronously mid-burst.
//    -> all outputs 0 immediately.
//    -> After release with en=1, streaming restarts from the current FIFO head.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the async-FIFO read-side streamer.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STOP   = 2'd2
  } state_t;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned BUF_IDX_W = $clog2(BUF_DEPTH);

endpackage

// File: rtl/stream_skid_buf.sv
// Small register FIFO that absorbs the read latency of the async FIFO.
// The head always sits in mem[0], so head_data is a plain register output.
module stream_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  input  logic                 clear,
  output logic [BUF_CNT_W-1:0] count,
  output logic [WIDTH-1:0]     head_data,
  output logic                 overflow
);

  logic [WIDTH-1:0]     mem [BUF_DEPTH];
  logic                 pop_ok;
  logic                 push_ok;
  logic [BUF_IDX_W-1:0] wr_idx;

  assign pop_ok    = pop && (count != '0);
  assign overflow  = push && !pop_ok && (count == BUF_CNT_W'(BUF_DEPTH));
  assign push_ok   = push && !overflow;
  assign head_data = mem[0];
  // New word lands behind whatever survives this cycle's pop.
  assign wr_idx    = BUF_IDX_W'(count - BUF_CNT_W'(pop_ok));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      count <= '0;
    end else begin
      if (pop_ok) begin
        for (int unsigned i = 0; i + 1 < BUF_DEPTH; i++) begin
          mem[i] <= mem[i+1];
        end
      end
      if (push_ok) begin
        mem[wr_idx] <= push_data;
      end
      count <= count + BUF_CNT_W'(push_ok) - BUF_CNT_W'(pop_ok);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(overflow && !clear));

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-side master for the async FIFO: pops words without underflow and
// presents them as a valid/ready stream at one word per clock.
module fifo_rd_streamer
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rdata,
  input  logic                 fifo_underflow,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_data,
  input  logic                 m_ready,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 busy,
  output logic                 err_underflow
);

  localparam int unsigned OUT_W = BUF_CNT_W + 1;

  state_t               state;
  state_t               state_nxt;
  logic                 inflight;
  logic                 drop;
  logic                 push;
  logic                 pop;
  logic                 overflow;
  logic [BUF_CNT_W-1:0] count;
  logic [OUT_W-1:0]     outstanding;

  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  // A return landing in a flush cycle is discarded instead of pushed.
  assign drop    = inflight && flush;
  assign push    = inflight && !drop;
  assign busy    = (state != IDLE) || m_valid;

  assign outstanding = OUT_W'(count) + OUT_W'(inflight) - OUT_W'(pop);
  assign fifo_rd_en  = (state == ACTIVE) && !fifo_empty && !flush &&
                       (outstanding < OUT_W'(BUF_DEPTH));

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = en ? ACTIVE : IDLE;
    end else begin
      unique case (state)
        IDLE:    if (en) state_nxt = ACTIVE;
        ACTIVE:  if (!en) state_nxt = STOP;
        STOP: begin
          if (en)            state_nxt = ACTIVE;
          else if (!inflight) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      inflight      <= 1'b0;
      word_count    <= '0;
      err_underflow <= 1'b0;
    end else begin
      state         <= state_nxt;
      inflight      <= fifo_rd_en;
      word_count    <= word_count + CNT_WIDTH'(pop);
      err_underflow <= err_underflow || fifo_underflow || overflow;
    end
  end

  stream_skid_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (fifo_rdata),
    .pop       (pop),
    .clear     (flush),
    .count     (count),
    .head_data (m_data),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed/randomized bench: FIFO model feeds the streamer, a word-order
// scoreboard and per-cycle invariants check the stream side.
module tb_fifo_rd_streamer;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n, en, flush, m_ready, force_uf;
  logic          fifo_empty, fifo_underflow, fifo_rd_en;
  logic [7:0]    fifo_rdata;
  logic          m_valid, busy, err_underflow;
  logic [7:0]    m_data;
  logic [CW-1:0] word_count;

  int         total = 0;
  int         bad = 0;
  logic [7:0] fmem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       uf_model = 1'b0;
  logic [7:0] exp_q [$];
  int         hs_total = 0;
  int         rd_total = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_streamer #(
    .WIDTH     (8),
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .flush          (flush),
    .fifo_empty     (fifo_empty),
    .fifo_rdata     (fifo_rdata),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_ready        (m_ready),
    .word_count     (word_count),
    .busy           (busy),
    .err_underflow  (err_underflow)
  );

  // Source FIFO: one-cycle read latency, flags underflow on a read while empty.
  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_underflow = uf_model | force_uf;
  initial fifo_rdata = '0;
  always @(posedge clk) begin
    if (rst_n && fifo_rd_en) begin
      if (wr_ptr == rd_ptr) uf_model <= 1'b1;
      else begin
        fifo_rdata <= fmem[rd_ptr % 256];
        rd_ptr     <= rd_ptr + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr % 256] = first + 8'(i);
      wr_ptr++;
    end
  endtask

  task automatic wait_valid(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m_valid) break;
    end
    chk(tag, m_valid, 1);
  endtask

  // Scoreboard: words read from the FIFO must appear in order, minus flushed ones.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hs_total   = 0;
      prev_stall = 1'b0;
    end else begin
      chk("wcount", word_count, hs_total % (1 << CW));
      chk("busy_cover", busy || !m_valid, 1);
      chk("no_rd_empty", fifo_rd_en && fifo_empty, 0);
      if (prev_stall) chk("stall_hold", {m_valid, m_data}, {1'b1, prev_data});
      if (m_valid && m_ready) begin
        chk("hs_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("order", m_data, exp_q.pop_front());
        hs_total++;
      end
      if (flush) begin
        chk("flush_no_rd", fifo_rd_en, 0);
        exp_q.delete();
      end
      if (fifo_rd_en) begin
        exp_q.push_back(fmem[rd_ptr % 256]);
        rd_total++;
      end
      chk("outstanding", exp_q.size() <= 2, 1);
      prev_stall = m_valid && !m_ready && !flush;
      prev_data  = m_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] rd_mask, v_mask;
    logic [7:0]  vm8, head;
    int          f, r0, w0, k;
    logic        prev_v;

    rst_n = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0; force_uf = 1'b0;
    #1 rst_n = 1'b0;
    #2 chk("reset_zero", {fifo_rd_en, m_valid, m_data, word_count, busy, err_underflow}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: five words streamed back-to-back
    preload(8'h11, 5); m_ready = 1'b1; en = 1'b1;
    rd_mask = '0; v_mask = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rd_mask[i] = fifo_rd_en;
      v_mask[i]  = m_valid;
    end
    f = -1;
    for (int i = 0; i < 12; i++) if (rd_mask[i] && f < 0) f = i;
    chk("t1_rd_start", (f >= 0) && (f <= 1), 1);
    if (f < 0) f = 0;
    chk("t1_rd_burst", rd_mask, 32'h1F << f);
    chk("t1_valid_lat", v_mask, 32'h1F << (f + 2));
    chk("t1_count", word_count, 5);
    @(posedge clk); #1 en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_idle", busy, 0);

    // 2: backpressure, exactly two reads, then a gapless drain
    @(posedge clk); #1 preload(8'h20, 8); m_ready = 1'b0; en = 1'b1; r0 = rd_total;
    repeat (8) @(negedge clk);
    chk("t2_reads", rd_total - r0, 2);
    chk("t2_head", {m_valid, m_data}, {1'b1, 8'h20});
    @(posedge clk); #1 m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vm8[i] = m_valid;
      chk("t2_seq", m_data, 8'h20 + 8'(i));
    end
    chk("t2_no_gap", vm8, 8'hFF);
    @(negedge clk);
    chk("t2_count", word_count, 13);

    // 3: empty FIFO, enabled
    r0 = rd_total;
    repeat (6) @(negedge clk);
    chk("t3_no_rd", rd_total - r0, 0);
    chk("t3_flags", {fifo_underflow, err_underflow, busy}, 3'b001);

    // 4: flush one cycle after an issue with one word buffered
    @(posedge clk); #1 m_ready = 1'b0; preload(8'hA0, 1);
    wait_valid("t4_first", 8);
    @(posedge clk); #1 preload(8'hB0, 1);
    @(negedge clk); chk("t4_issue", fifo_rd_en, 1);
    @(posedge clk); #1 flush = 1'b1; preload(8'h30, 3);
    @(negedge clk); chk("t4_flush_rd", fifo_rd_en, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk); chk("t4_valid_off", m_valid, 0);
    wait_valid("t4_resume_v", 8);
    chk("t4_resume", m_data, 8'h30);
    @(posedge clk); #1 m_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("t4_wrap", word_count, 0);

    // 5: drop en with a read outstanding
    r0 = rd_total; w0 = hs_total;
    @(posedge clk); #1 preload(8'h40, 3);
    @(negedge clk); chk("t5_issue", fifo_rd_en, 1);
    @(posedge clk); #1 en = 1'b0;
    prev_v = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!busy) break;
      prev_v = m_valid;
    end
    k = rd_total - r0;
    chk("t5_idle", busy, 0);
    chk("t5_busy_after_pop", prev_v, 1);
    chk("t5_delivered", hs_total - w0, k);
    chk("t5_left", wr_ptr - rd_ptr, 3 - k);

    // 6: async reset mid-burst, restart from FIFO head
    @(posedge clk); #1 preload(8'h50 + 8'($urandom_range(0, 15)), 16); en = 1'b1;
    repeat (6 + $urandom_range(0, 3)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_reset", {fifo_rd_en, m_valid, m_data, word_count, busy, err_underflow}, 0);
    @(negedge clk);
    @(posedge clk); #1 head = fmem[rd_ptr % 256]; rst_n = 1'b1;
    wait_valid("t6_valid", 8);
    chk("t6_restart", m_data, head);

    // sticky error flag
    @(posedge clk); #1 force_uf = 1'b1;
    @(posedge clk); #1 force_uf = 1'b0;
    @(negedge clk); chk("err_set", err_underflow, 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", err_underflow, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("err_reset", err_underflow, 0);
    @(posedge clk); #1 rst_n = 1'b1; en = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
